// File: rtl/a3_cpu_pkg.sv
// Shared fetch-path types and control-bus codes for the A3 CPU.
package a3_cpu_pkg;

    localparam int CTL_OP_WIDTH   = 8;
    localparam int CTL_DATA_WIDTH = 64;

    localparam logic [CTL_OP_WIDTH-1:0] CTL_NOP       = 8'h00;
    localparam logic [CTL_OP_WIDTH-1:0] CTL_READ_ADDR = 8'h02;
    localparam logic [CTL_OP_WIDTH-1:0] CTL_ACK       = 8'h01;

    typedef enum logic {
        ISSUE = 1'b0,
        WAIT  = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_wdog.sv
// Request timeout counter: clear has priority, counts while enabled, and
// pulses expire on the cycle the count sits at TIMEOUT-1.
module pc_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    assign expire = en && !clr && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr || expire) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Handshaked program-counter / instruction-fetch sequencer for the A3 CPU:
// one read request per PC, advance on ack, redirect, stall and timeout retry.
module pc_fetch
    import a3_cpu_pkg::pc_state_t, a3_cpu_pkg::ISSUE, a3_cpu_pkg::WAIT,
           a3_cpu_pkg::CTL_NOP, a3_cpu_pkg::CTL_OP_WIDTH, a3_cpu_pkg::CTL_DATA_WIDTH;
#(
    parameter int                        ADDR_WIDTH    = 17,
    parameter int                        INSN_BYTES    = 4,
    parameter logic [ADDR_WIDTH-1:0]     RESET_VECTOR  = '0,
    parameter logic [CTL_OP_WIDTH-1:0]   CTL_READ_ADDR = a3_cpu_pkg::CTL_READ_ADDR,
    parameter logic [CTL_OP_WIDTH-1:0]   CTL_ACK       = a3_cpu_pkg::CTL_ACK,
    parameter int                        TIMEOUT       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                bus_data_in,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_addr,
    output logic [CTL_OP_WIDTH-1:0]   ctl_op_out,
    output logic [CTL_DATA_WIDTH-1:0] ctl_data_out,
    output logic [ADDR_WIDTH-1:0]     pc_out,
    output logic                      fetch_done,
    output logic                      misalign_out,
    output logic                      retry_out
);

    // state | meaning
    // ISSUE | drive a read request for pc_q unless stalled
    // WAIT  | request outstanding; wait for ack, redirect or timeout
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSN_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSN_BYTES);

    pc_state_t                 state_q, state_d;
    logic [CTL_OP_WIDTH-1:0]   ctl_op_q, ctl_op_d;
    logic [CTL_DATA_WIDTH-1:0] ctl_data_q, ctl_data_d;
    logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
    logic                      fetch_done_q, fetch_done_d;
    logic                      misalign_q, misalign_d;
    logic                      retry_q, retry_d;
    logic                      ack, wdog_clr, wdog_en, wdog_expire;

    assign ack      = (bus_data_in == CTL_ACK);
    assign wdog_en  = (state_q == WAIT);
    assign wdog_clr = redirect_valid || ack || (state_q == ISSUE);

    pc_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wdog_clr),
        .en     (wdog_en),
        .expire (wdog_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ISSUE;
        end else begin
            case (state_q)
                ISSUE: if (!stall) state_d = WAIT;
                WAIT:  if (ack || wdog_expire) state_d = ISSUE;
                default: state_d = ISSUE;
            endcase
        end
    end

    // Redirect wins over everything, so a coincident ack is simply dropped.
    always_comb begin
        ctl_op_d     = CTL_NOP;
        ctl_data_d   = ctl_data_q;
        pc_d         = pc_q;
        fetch_done_d = 1'b0;
        misalign_d   = 1'b0;
        retry_d      = 1'b0;
        if (redirect_valid) begin
            pc_d       = redirect_addr & ~ALIGN_MASK;
            misalign_d = |(redirect_addr & ALIGN_MASK);
        end else begin
            case (state_q)
                ISSUE: begin
                    if (!stall) begin
                        ctl_op_d   = CTL_READ_ADDR;
                        ctl_data_d = CTL_DATA_WIDTH'(pc_q);
                    end
                end
                WAIT: begin
                    if (ack) begin
                        pc_d         = pc_q + PC_STEP;
                        fetch_done_d = 1'b1;
                    end else if (wdog_expire) begin
                        retry_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_op_q     <= CTL_NOP;
            ctl_data_q   <= '0;
            pc_q         <= RESET_VECTOR;
            fetch_done_q <= 1'b0;
            misalign_q   <= 1'b0;
            retry_q      <= 1'b0;
        end else begin
            ctl_op_q     <= ctl_op_d;
            ctl_data_q   <= ctl_data_d;
            pc_q         <= pc_d;
            fetch_done_q <= fetch_done_d;
            misalign_q   <= misalign_d;
            retry_q      <= retry_d;
        end
    end

    assign ctl_op_out   = ctl_op_q;
    assign ctl_data_out = ctl_data_q;
    assign pc_out       = pc_q;
    assign fetch_done   = fetch_done_q;
    assign misalign_out = misalign_q;
    assign retry_out    = retry_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: expected request addresses go into a
// scoreboard queue when stimulus is driven and are popped when a request appears.
module tb_pc_fetch;

    localparam logic [7:0] OP_READ = 8'h02;
    localparam logic [7:0] OP_ACK  = 8'h01;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bus_data_in;
    logic        stall;
    logic        redirect_valid;
    logic [16:0] redirect_addr;
    logic [7:0]  ctl_op_out;
    logic [63:0] ctl_data_out;
    logic [16:0] pc_out;
    logic        fetch_done;
    logic        misalign_out;
    logic        retry_out;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    pc_fetch #(
        .ADDR_WIDTH (17),
        .INSN_BYTES (4),
        .TIMEOUT    (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_data_in    (bus_data_in),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .ctl_op_out     (ctl_op_out),
        .ctl_data_out   (ctl_data_out),
        .pc_out         (pc_out),
        .fetch_done     (fetch_done),
        .misalign_out   (misalign_out),
        .retry_out      (retry_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output logic [63:0] e);
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
    endtask

    // Leaves the bench in the first cycle with reset low (state ISSUE).
    task automatic do_reset();
        reset = 1'b1; bus_data_in = 8'h00; stall = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_data_in = OP_ACK; stall = 1'b0;
        redirect_valid = 1'b1; redirect_addr = 17'h00085;
        tick(); tick();
        checks++; if (pc_out !== 17'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc_out); end
        checks++; if (ctl_op_out !== 8'h00) begin errors++; $display("FAIL reset_op: got %h exp 00", ctl_op_out); end
        checks++; if (ctl_data_out !== 64'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", ctl_data_out); end
        checks++; if ({fetch_done, misalign_out, retry_out} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b exp 000", {fetch_done, misalign_out, retry_out});
        end
        redirect_valid = 1'b0; bus_data_in = 8'h00;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [63:0] e;
        logic [16:0] pc_model;
        do_reset();
        pc_model = 17'h0;
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(i * 4));
        for (int i = 0; i < 4; i++) begin
            tick();
            pop_exp(e);
            checks++; if (ctl_op_out !== OP_READ) begin errors++; $display("FAIL seq_op[%0d]: got %h exp %h", i, ctl_op_out, OP_READ); end
            checks++; if (ctl_data_out !== e) begin errors++; $display("FAIL seq_addr[%0d]: got %h exp %h", i, ctl_data_out, e); end
            bus_data_in = OP_ACK;
            tick();
            bus_data_in = 8'h00;
            pc_model = pc_model + 17'd4;
            checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL seq_done[%0d]: got %b exp 1", i, fetch_done); end
            checks++; if (pc_out !== pc_model) begin errors++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, pc_out, pc_model); end
            checks++; if (ctl_op_out !== 8'h00) begin errors++; $display("FAIL seq_nop[%0d]: got %h exp 00", i, ctl_op_out); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] e;
        do_reset();
        redirect_valid = 1'b1; redirect_addr = 17'h1FFFC;
        exp_q.push_back(64'h1FFFC);
        tick();
        redirect_valid = 1'b0;
        checks++; if (pc_out !== 17'h1FFFC) begin errors++; $display("FAIL wrap_redir_pc: got %h exp 1fffc", pc_out); end
        checks++; if (ctl_op_out !== 8'h00) begin errors++; $display("FAIL wrap_redir_op: got %h exp 00", ctl_op_out); end
        tick();
        pop_exp(e);
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== e) begin
            errors++; $display("FAIL wrap_req: got op %h addr %h exp op %h addr %h", ctl_op_out, ctl_data_out, OP_READ, e);
        end
        bus_data_in = OP_ACK;
        exp_q.push_back(64'h0);
        tick();
        bus_data_in = 8'h00;
        checks++; if (pc_out !== 17'h0) begin errors++; $display("FAIL wrap_pc: got %h exp 0", pc_out); end
        checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b exp 1", fetch_done); end
        tick();
        pop_exp(e);
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== e) begin
            errors++; $display("FAIL wrap_next_req: got op %h addr %h exp op %h addr %h", ctl_op_out, ctl_data_out, OP_READ, e);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] e;
        do_reset();
        exp_q.push_back(64'h0);
        tick();
        pop_exp(e);
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== e) begin
            errors++; $display("FAIL mis_first_req: got op %h addr %h exp op %h addr %h", ctl_op_out, ctl_data_out, OP_READ, e);
        end
        bus_data_in = OP_ACK; redirect_valid = 1'b1; redirect_addr = 17'h00105;
        exp_q.push_back(64'h104);
        tick();
        bus_data_in = 8'h00; redirect_valid = 1'b0;
        checks++; if (pc_out !== 17'h00104) begin errors++; $display("FAIL mis_pc: got %h exp 104", pc_out); end
        checks++; if (misalign_out !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b exp 1", misalign_out); end
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL mis_done: got %b exp 0", fetch_done); end
        tick();
        pop_exp(e);
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== e) begin
            errors++; $display("FAIL mis_req: got op %h addr %h exp op %h addr %h", ctl_op_out, ctl_data_out, OP_READ, e);
        end
        checks++; if (misalign_out !== 1'b0) begin errors++; $display("FAIL mis_pulse_width: got %b exp 0", misalign_out); end
    endtask

    task automatic test_stall();
        logic [63:0] e;
        int bad_op;
        do_reset();
        exp_q.push_back(64'h0);
        tick();
        pop_exp(e);
        checks++; if (ctl_data_out !== e) begin errors++; $display("FAIL stall_pre_req: got %h exp %h", ctl_data_out, e); end
        bus_data_in = OP_ACK;
        tick();
        bus_data_in = 8'h00;
        stall = 1'b1;
        bad_op = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ctl_op_out !== 8'h00 || pc_out !== 17'h4) bad_op++;
        end
        checks++; if (bad_op !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles exp 0", bad_op); end
        stall = 1'b0;
        exp_q.push_back(64'h4);
        tick();
        pop_exp(e);
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== e) begin
            errors++; $display("FAIL stall_release_req: got op %h addr %h exp op %h addr %h", ctl_op_out, ctl_data_out, OP_READ, e);
        end
        bus_data_in = OP_ACK;
        tick();
        bus_data_in = 8'h00;
        stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 17'h00040;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (ctl_op_out !== 8'h00 || pc_out !== 17'h40) begin
            errors++; $display("FAIL stall_redir_hold: got op %h pc %h exp op 00 pc 40", ctl_op_out, pc_out);
        end
        stall = 1'b0;
        exp_q.push_back(64'h40);
        tick();
        pop_exp(e);
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== e) begin
            errors++; $display("FAIL stall_redir_req: got op %h addr %h exp op %h addr %h", ctl_op_out, ctl_data_out, OP_READ, e);
        end
    endtask

    task automatic test_timeout();
        logic [63:0] e;
        int waited, bad_op;
        do_reset();
        exp_q.push_back(64'h0);
        tick();
        pop_exp(e);
        checks++; if (ctl_data_out !== e) begin errors++; $display("FAIL to_first_req: got %h exp %h", ctl_data_out, e); end
        bus_data_in = 8'hFE;
        exp_q.push_back(64'h0);
        waited = 0; bad_op = 0;
        while (waited < 40) begin
            tick();
            waited++;
            if (ctl_op_out !== 8'h00) bad_op++;
            if (retry_out === 1'b1) break;
        end
        checks++; if (waited !== 16) begin errors++; $display("FAIL to_retry_time: got %0d cycles exp 16", waited); end
        checks++; if (bad_op !== 0) begin errors++; $display("FAIL to_quiet_bus: got %0d requests exp 0", bad_op); end
        checks++; if (pc_out !== 17'h0) begin errors++; $display("FAIL to_pc: got %h exp 0", pc_out); end
        tick();
        pop_exp(e);
        checks++; if (retry_out !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b exp 0", retry_out); end
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== e) begin
            errors++; $display("FAIL to_reissue: got op %h addr %h exp op %h addr %h", ctl_op_out, ctl_data_out, OP_READ, e);
        end
        bus_data_in = 8'h00;
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] e;
        do_reset();
        tick();
        bus_data_in = OP_ACK;
        tick();
        bus_data_in = 8'h00;
        tick();
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== 64'h4) begin
            errors++; $display("FAIL rmw_pre_req: got op %h addr %h exp op 02 addr 4", ctl_op_out, ctl_data_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_data_in = OP_ACK;
        exp_q.push_back(64'h0);
        checks++; if (pc_out !== 17'h0) begin errors++; $display("FAIL rmw_pc_reset: got %h exp 0", pc_out); end
        tick();
        bus_data_in = 8'h00;
        pop_exp(e);
        checks++; if (fetch_done !== 1'b0 || pc_out !== 17'h0) begin
            errors++; $display("FAIL rmw_late_ack: got done %b pc %h exp done 0 pc 0", fetch_done, pc_out);
        end
        checks++; if (ctl_op_out !== OP_READ || ctl_data_out !== e) begin
            errors++; $display("FAIL rmw_first_req: got op %h addr %h exp op %h addr %h", ctl_op_out, ctl_data_out, OP_READ, e);
        end
        tick();
        checks++; if (fetch_done !== 1'b0 || pc_out !== 17'h0) begin
            errors++; $display("FAIL rmw_settle: got done %b pc %h exp done 0 pc 0", fetch_done, pc_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_misalign();
        test_stall();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
